// File: rtl/tdc_pkg.sv
// Shared constants and state type for the TDC measurement sequencer.
package tdc_pkg;

  localparam int TAP_W_DEF    = 21;
  localparam int COARSE_W_DEF = 16;
  localparam int FINE_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ARMED  = 3'd2,
    ST_ENCODE = 3'd3,
    ST_DONE   = 3'd4
  } tdc_state_t;

endpackage

// File: rtl/tdc_therm2bin.sv
// Counts the ones in a delay-line snapshot; a full popcount tolerates bubbles
// that would corrupt a leading-one search.
module tdc_therm2bin
  import tdc_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEF
) (
  input  logic [TAP_W-1:0]  i_therm,
  output logic [FINE_W-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < TAP_W; i++) begin
      o_count = o_count + FINE_W'(i_therm[i]);
    end
  end

endmodule

// File: rtl/tdc_sequencer.sv
// One-shot TDC measurement sequencer: clear the line, arm it, count whole
// cycles until the first tap fires (or time out), encode the fine code, hand off.
module tdc_sequencer
  import tdc_pkg::*;
#(
  parameter int TAP_W    = TAP_W_DEF,
  parameter int COARSE_W = COARSE_W_DEF,
  parameter int TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TAP_W-1:0]    tdc_data,
  output logic                tdc_en,
  output logic                tdc_clr,
  output logic                busy,
  output logic                meas_valid,
  input  logic                meas_ready,
  output logic [FINE_W-1:0]   meas_fine,
  output logic [COARSE_W-1:0] meas_coarse,
  output logic                meas_timeout
);

  localparam logic [COARSE_W-1:0] LAST_CNT = COARSE_W'(TIMEOUT - 1);
  localparam logic [COARSE_W-1:0] TO_CNT   = COARSE_W'(TIMEOUT);

  tdc_state_t          r_state;
  logic [COARSE_W-1:0] r_count;
  logic [TAP_W-1:0]    r_capture;
  logic                r_tdc_en;
  logic                r_tdc_clr;
  logic                r_busy;
  logic                r_meas_valid;
  logic [FINE_W-1:0]   r_meas_fine;
  logic [COARSE_W-1:0] r_meas_coarse;
  logic                r_meas_timeout;
  logic [FINE_W-1:0]   w_fine;

  tdc_therm2bin #(.TAP_W(TAP_W)) u_therm2bin (
    .i_therm (r_capture),
    .o_count (w_fine)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_count        <= '0;
      r_capture      <= '0;
      r_tdc_en       <= 1'b0;
      r_tdc_clr      <= 1'b0;
      r_busy         <= 1'b0;
      r_meas_valid   <= 1'b0;
      r_meas_fine    <= '0;
      r_meas_coarse  <= '0;
      r_meas_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tdc_clr <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_tdc_clr <= 1'b0;
          r_tdc_en  <= 1'b1;
          r_count   <= '0;
          r_state   <= ST_ARMED;
        end
        ST_ARMED: begin
          // A hit on the final armed cycle still counts as a hit.
          if (tdc_data[0]) begin
            r_capture <= tdc_data;
            r_tdc_en  <= 1'b0;
            r_state   <= ST_ENCODE;
          end else if (r_count == LAST_CNT) begin
            r_tdc_en       <= 1'b0;
            r_meas_valid   <= 1'b1;
            r_meas_timeout <= 1'b1;
            r_meas_fine    <= '0;
            r_meas_coarse  <= TO_CNT;
            r_state        <= ST_DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_ENCODE: begin
          r_meas_fine    <= w_fine;
          r_meas_coarse  <= r_count;
          r_meas_timeout <= 1'b0;
          r_meas_valid   <= 1'b1;
          r_state        <= ST_DONE;
        end
        ST_DONE: begin
          if (meas_ready) begin
            r_meas_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tdc_en       = r_tdc_en;
  assign tdc_clr      = r_tdc_clr;
  assign busy         = r_busy;
  assign meas_valid   = r_meas_valid;
  assign meas_fine    = r_meas_fine;
  assign meas_coarse  = r_meas_coarse;
  assign meas_timeout = r_meas_timeout;

endmodule

// File: doc/tdc_sequencer.md
TDC_SEQUENCER -- requirements
Module: tdc_sequencer

Interface
REQ-001 Parameter TAP_W, default 21: width of the tapped-delay-line snapshot word.
REQ-002 Parameter COARSE_W, default 16: width of the coarse cycle counter.
REQ-003 Parameter TIMEOUT, default 1000: ARMED cycles before abort; legal range 2..2^COARSE_W-1.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin one measurement.
REQ-007 tdc_data  in  TAP_W  thermometer snapshot from the delay line, sampled each clk.
REQ-008 tdc_en  out  1  enables the delay line; high only in ARMED.
REQ-009 tdc_clr  out  1  clears delay-line latches; high only in CLEAR.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 meas_valid  out  1  result available; high only in DONE.
REQ-012 meas_ready  in  1  consumer accepts result.
REQ-013 meas_fine  out  5  fine time: count of ones in captured snapshot (0..21).
REQ-014 meas_coarse  out  COARSE_W  whole clk cycles from arm to hit.
REQ-015 meas_timeout  out  1  result is a timeout, not a hit.

Function
REQ-016 States IDLE, CLEAR, ARMED, ENCODE, DONE; one-hot or binary, encoding from package.
REQ-017 IDLE: start=1 -> CLEAR; all other inputs ignored; tdc_data ignored.
REQ-018 CLEAR: exactly one cycle, tdc_clr=1, coarse counter loaded 0, -> ARMED.
REQ-019 ARMED: tdc_en=1; coarse counter +1 per cycle; tdc_data[0]=1 -> register tdc_data into capture reg, -> ENCODE.
REQ-020 ARMED: counter reaching TIMEOUT-1 with tdc_data[0]=0 -> DONE, meas_timeout=1, meas_fine=0, meas_coarse=TIMEOUT.
REQ-021 Simultaneous hit and timeout in same cycle: hit wins, meas_timeout=0.
REQ-022 ENCODE: one cycle; meas_fine = popcount(capture reg) (bubble-tolerant, not leading-one); meas_coarse = counter value at hit cycle; -> DONE.
REQ-023 Latency: hit sampled in ARMED at cycle N -> meas_valid high at cycle N+2.
REQ-024 DONE: meas_valid and all meas_* held stable until meas_valid&meas_ready; then -> IDLE next cycle.
REQ-025 start while busy=1 ignored (no queuing); start in the DONE-acceptance cycle ignored.
REQ-026 meas_ready outside DONE has no effect.
REQ-027 Coarse counter never wraps; TIMEOUT bound guarantees it.
REQ-028 meas_* outputs registered; no combinational path from any input to any output.

Reset
REQ-029 rst=1 at any clk edge -> IDLE next cycle, regardless of state (mid-measurement abort, result discarded).
REQ-030 Reset values: tdc_en=0, tdc_clr=0, busy=0, meas_valid=0, meas_fine=0, meas_coarse=0, meas_timeout=0, capture reg=0, counter=0.
REQ-031 rst overrides start in the same cycle.

Structure
REQ-032 Shared package tdc_pkg holds TAP_W and COARSE_W defaults, fine-width constant (5), and the state typedef.
REQ-033 One sub-module tdc_therm2bin: combinational TAP_W-bit popcount to 5-bit count, instantiated in ENCODE path.
REQ-034 Top contains only FSM, coarse counter, capture register and output registers.

Verification
REQ-035 start, tdc_data[0]=1 with 0x0000FF on 4th ARMED cycle -> meas_fine=8, meas_coarse=3, valid 2 cycles later.
REQ-036 start, tdc_data=0 forever, TIMEOUT=10 -> DONE after 10 ARMED cycles, meas_timeout=1, meas_coarse=10, meas_fine=0.
REQ-037 Bubbled snapshot 0x00002D (ones=4) -> meas_fine=4; all-ones 0x1FFFFF -> meas_fine=21.
REQ-038 meas_ready held 0 for 5 cycles in DONE, start pulsed -> outputs stable, start ignored, IDLE after ready.
REQ-039 rst asserted in ARMED cycle 2 -> next cycle busy=0, tdc_en=0, no meas_valid afterwards.
REQ-040 Hit on exact timeout cycle (TIMEOUT=10, hit at counter 9) -> meas_timeout=0, meas_coarse=9.
